// File: rtl/mem_fifo_seq_ctrl.sv
// rtl/mem_fifo_seq_ctrl.sv - FIFO-mode bring-up and run sequencer for memory_core
// Optional config readback/verify: define CFG_READBACK_EN.
module mem_fifo_seq_ctrl #(
    parameter logic [31:0] CFG_BASE  = 32'h0,
    parameter int          FLUSH_CYC = 2,
    parameter int          CNT_W     = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [15:0]      cfg_depth,
    input  logic [3:0]       cfg_almost,
    input  logic             push_req,
    input  logic             pop_req,
    output logic             push_ack,
    output logic             pop_ack,
    output logic             wen_in,
    output logic             ren_in,
    output logic             flush,
    output logic [31:0]      config_addr,
    output logic [31:0]      config_data,
    output logic             config_write,
    output logic             config_read,
    input  logic [31:0]      read_config_data,
    input  logic             full,
    input  logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             mismatch_err,
    output logic             cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_FLUSH,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       idx;
    logic [7:0]       flush_cnt;
    logic [15:0]      depth_r;
    logic [3:0]       almost_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] depth_ext;
    logic             empty_r, full_r, zero_r, top_r, chk_q;
    logic             done_r, mismatch_r, cfg_err_r;
    logic [31:0]      cfg_word;
    logic             in_cfg, cfg_wr, cfg_rd, cfg_bad, last_step;
    logic             push_ok, pop_ok;
`ifdef CFG_READBACK_EN
    logic [1:0]       phase;
`else
    logic             unused_rcd;
    assign unused_rcd = ^read_config_data;
`endif

    assign depth_ext = CNT_W'(depth_r);
    assign in_cfg    = (state == S_CFG);

    always_comb begin
        cfg_word = 32'h1;
        case (idx)
            2'd1:    cfg_word = {16'h0, depth_r};
            2'd2:    cfg_word = {28'h0, almost_r};
            default: cfg_word = 32'h1;
        endcase
    end

    // Readback build: each word steps write -> read -> compare.
`ifdef CFG_READBACK_EN
    assign cfg_wr    = in_cfg && (phase == 2'd0);
    assign cfg_rd    = in_cfg && (phase == 2'd1);
    assign cfg_bad   = in_cfg && (phase == 2'd2) && (read_config_data != cfg_word);
    assign last_step = in_cfg && (phase == 2'd2) && (idx == 2'd3);
`else
    assign cfg_wr    = in_cfg;
    assign cfg_rd    = 1'b0;
    assign cfg_bad   = 1'b0;
    assign last_step = in_cfg && (idx == 2'd3);
`endif

    // A stop cycle already refuses pushes so the drain never grows.
    assign push_ok = (state == S_RUN) && !stop && push_req && (count_r < depth_ext);
    assign pop_ok  = ((state == S_RUN) || (state == S_DRAIN)) && pop_req && (count_r != '0);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CFG;
            S_CFG: begin
                if (cfg_bad)
                    state_nxt = S_IDLE;
                else if (last_step)
                    state_nxt = S_FLUSH;
            end
            S_FLUSH: if (flush_cnt == 8'(FLUSH_CYC - 1)) state_nxt = S_RUN;
            S_RUN:   if (stop) state_nxt = S_DRAIN;
            S_DRAIN: if (count_r == '0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            idx        <= 2'd0;
            flush_cnt  <= 8'd0;
            depth_r    <= 16'd0;
            almost_r   <= 4'd0;
            count_r    <= '0;
            empty_r    <= 1'b0;
            full_r     <= 1'b0;
            zero_r     <= 1'b0;
            top_r      <= 1'b0;
            chk_q      <= 1'b0;
            done_r     <= 1'b0;
            mismatch_r <= 1'b0;
            cfg_err_r  <= 1'b0;
`ifdef CFG_READBACK_EN
            phase      <= 2'd0;
`endif
        end else begin
            state  <= state_nxt;
            done_r <= (state == S_DRAIN) && (state_nxt == S_IDLE);

            if (state == S_IDLE && start) begin
                depth_r  <= (cfg_depth == 16'd0) ? 16'd1 : cfg_depth;
                almost_r <= cfg_almost;
                idx      <= 2'd0;
`ifdef CFG_READBACK_EN
                phase    <= 2'd0;
`endif
            end else if (in_cfg) begin
`ifdef CFG_READBACK_EN
                if (phase == 2'd2) begin
                    phase <= 2'd0;
                    idx   <= idx + 2'd1;
                end else begin
                    phase <= phase + 2'd1;
                end
                if (cfg_bad)
                    cfg_err_r <= 1'b1;
`else
                idx <= idx + 2'd1;
`endif
            end

            flush_cnt <= (state == S_FLUSH) ? flush_cnt + 8'd1 : 8'd0;

            if (state == S_FLUSH)
                count_r <= '0;
            else if (push_ok && !pop_ok)
                count_r <= count_r + CNT_W'(1);
            else if (pop_ok && !push_ok)
                count_r <= count_r - CNT_W'(1);

            // Core flags and shadow flags are sampled together, compared a cycle later.
            empty_r <= empty;
            full_r  <= full;
            zero_r  <= (count_r == '0);
            top_r   <= (count_r == depth_ext);
            chk_q   <= (state == S_RUN) || (state == S_DRAIN);
            if (chk_q && ((empty_r != zero_r) || (full_r != top_r)))
                mismatch_r <= 1'b1;
        end
    end

    assign push_ack     = push_ok;
    assign pop_ack      = pop_ok;
    assign wen_in       = push_ok;
    assign ren_in       = pop_ok;
    assign flush        = (state == S_FLUSH);
    assign config_write = cfg_wr;
    assign config_read  = cfg_rd;
    assign config_addr  = in_cfg ? (CFG_BASE + {30'h0, idx}) : 32'h0;
    assign config_data  = in_cfg ? cfg_word : 32'h0;
    assign count        = count_r;
    assign busy         = (state != S_IDLE);
    assign done         = done_r;
    assign mismatch_err = mismatch_r;
`ifdef CFG_READBACK_EN
    assign cfg_err      = cfg_err_r;
`else
    assign cfg_err      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_fifo_seq_ctrl.sv
// tb/tb_mem_fifo_seq_ctrl.sv - self-checking bench for mem_fifo_seq_ctrl
module tb_mem_fifo_seq_ctrl;

    localparam int FLUSH_CYC = 2;
    localparam int CNT_W     = 17;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0, stop = 1'b0;
    logic [15:0]      cfg_depth = 16'd0;
    logic [3:0]       cfg_almost = 4'd0;
    logic             push_req = 1'b0, pop_req = 1'b0;
    logic             push_ack, pop_ack, wen_in, ren_in, flush;
    logic [31:0]      config_addr, config_data, read_config_data;
    logic             config_write, config_read, full, empty;
    logic [CNT_W-1:0] count;
    logic             busy, done, mismatch_err, cfg_err;

    always #5 clk = ~clk;

    mem_fifo_seq_ctrl #(.CFG_BASE(32'h0), .FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .cfg_depth(cfg_depth), .cfg_almost(cfg_almost),
        .push_req(push_req), .pop_req(pop_req), .push_ack(push_ack), .pop_ack(pop_ack),
        .wen_in(wen_in), .ren_in(ren_in), .flush(flush),
        .config_addr(config_addr), .config_data(config_data),
        .config_write(config_write), .config_read(config_read),
        .read_config_data(read_config_data), .full(full), .empty(empty),
        .count(count), .busy(busy), .done(done),
        .mismatch_err(mismatch_err), .cfg_err(cfg_err)
    );

    // Behavioural memory_core stand-in: occupancy, flags and config storage.
    int          core_cnt = 0;
    int          mdepth = 1;
    int          mcnt = 0;
    logic        inj = 1'b0, corrupt = 1'b0;
    logic [31:0] cfg_mem [4];
    logic [31:0] rcd = 32'h0;

    always @(posedge clk) begin
        if (flush) core_cnt <= 0;
        else       core_cnt <= core_cnt + int'(wen_in) - int'(ren_in);
        if (config_write) cfg_mem[config_addr[1:0]] <= config_data;
        if (config_read)
            rcd <= cfg_mem[config_addr[1:0]] ^ ((corrupt && config_addr[1:0] == 2'd1) ? 32'h10 : 32'h0);
    end
    assign full             = (core_cnt == mdepth);
    assign empty            = (core_cnt == 0) ^ inj;
    assign read_config_data = rcd;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_flush"}, flush, 0);
        chk({tag, "_cfg_wr"}, config_write, 0);
        chk({tag, "_cfg_rd"}, config_read, 0);
        chk({tag, "_cfg_addr"}, config_addr, 0);
        chk({tag, "_cfg_data"}, config_data, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_wen"}, wen_in, 0);
        chk({tag, "_ren"}, ren_in, 0);
        chk({tag, "_mismatch"}, mismatch_err, 0);
        chk({tag, "_cfg_err"}, cfg_err, 0);
    endtask

    // Drives start and checks the full config + flush sequence; returns in the first RUN cycle.
    task automatic bring_up(input int d, input int a);
        logic [31:0] w [4];
        int eff;
        eff  = (d == 0) ? 1 : d;
        w[0] = 32'h1; w[1] = eff; w[2] = a; w[3] = 32'h1;
        cfg_depth = d[15:0]; cfg_almost = a[3:0];
        push_req = 1'b0; pop_req = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        mdepth = eff;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("cfg%0d_wr", i), config_write, 1);
            chk($sformatf("cfg%0d_addr", i), config_addr, i);
            chk($sformatf("cfg%0d_data", i), config_data, w[i]);
            chk($sformatf("cfg%0d_flush", i), flush, 0);
`ifdef CFG_READBACK_EN
            tick;
            chk($sformatf("cfg%0d_rd", i), config_read, 1);
            chk($sformatf("cfg%0d_rd_wr", i), config_write, 0);
            chk($sformatf("cfg%0d_rd_addr", i), config_addr, i);
            tick;
            chk($sformatf("cfg%0d_cmp_wr", i), config_write, 0);
`else
            chk($sformatf("cfg%0d_rd", i), config_read, 0);
`endif
            tick;
        end
        for (int i = 0; i < FLUSH_CYC; i++) begin
            chk($sformatf("flush%0d", i), flush, 1);
            chk($sformatf("flush%0d_wr", i), config_write, 0);
            tick;
            chk($sformatf("flush%0d_count", i), count, 0);
        end
        chk("run_flush_low", flush, 0);
        chk("run_busy", busy, 1);
        mcnt = 0;
    endtask

    task automatic run_vec(input string nm, input logic p, input logic q, input logic s,
                           input logic ep, input logic eq, input int ec);
        push_req = p; pop_req = q; stop = s;
        #1;
        chk({nm, "_push_ack"}, push_ack, ep);
        chk({nm, "_pop_ack"}, pop_ack, eq);
        chk({nm, "_wen"}, wen_in, ep);
        chk({nm, "_ren"}, ren_in, eq);
        tick;
        stop = 1'b0;
        chk({nm, "_count"}, count, ec);
    endtask

    // Reference: accept rules straight from the occupancy arithmetic.
    task automatic model_step(input string nm, input logic p, input logic q, input logic s, input bit running);
        logic ep, eq;
        ep = running && p && !s && (mcnt < mdepth);
        eq = q && (mcnt > 0);
        if (ep && !eq) mcnt = mcnt + 1;
        if (eq && !ep) mcnt = mcnt - 1;
        run_vec(nm, p, q, s, ep, eq, mcnt);
    endtask

    task automatic finish_drain(input string tag);
        push_req = 1'b0; pop_req = 1'b0;
        chk({tag, "_last_busy"}, busy, 1);
        chk({tag, "_last_done"}, done, 0);
        tick;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_low"}, busy, 0);
        tick;
        chk({tag, "_done_once"}, done, 0);
        chk({tag, "_mismatch"}, mismatch_err, 0);
    endtask

    typedef struct {
        logic push, pop, stop, e_push, e_pop;
        int   e_cnt;
    } vec_t;
    vec_t vecs [11];

    initial begin
        int guard, flush_seen, wr_seen;
        vecs = '{
            '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1},
            '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2},
            '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3},
            '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4},
            '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4},
            '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4},
            '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3},
            '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2},
            '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1},
            '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0}
        };

        reset = 1'b1;
        push_req = 1'b1; pop_req = 1'b1;
        repeat (2) tick;
        reset = 1'b0;
        push_req = 1'b0; pop_req = 1'b0;
        chk_idle("reset");

        bring_up(4, 0);
        for (int i = 0; i < 11; i++)
            run_vec($sformatf("vec%0d", i), vecs[i].push, vecs[i].pop, vecs[i].stop,
                    vecs[i].e_push, vecs[i].e_pop, vecs[i].e_cnt);
        finish_drain("tbl");

        // Reset mid-RUN, then a second bring-up from scratch.
        bring_up(4, 2);
        for (int i = 0; i < 3; i++) model_step("pre_rst", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("pre_rst_count", count, 3);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        push_req = 1'b0;
        chk_idle("midrst");
        bring_up(4, 2);

        // start ignored in RUN; forced empty disagreement latches mismatch_err.
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("start_ignored_wr", config_write, 0);
        chk("start_ignored_busy", busy, 1);
        chk("mm_before", mismatch_err, 0);
        inj = 1'b1;
        tick;
        inj = 1'b0;
        tick;
        tick;
        chk("mm_set", mismatch_err, 1);
        tick;
        chk("mm_sticky", mismatch_err, 1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("mm_cleared", mismatch_err, 0);

        // Randomized rounds against the occupancy model; round 0 exercises depth 0.
        for (int r = 0; r < 3; r++) begin
            bring_up((r == 0) ? 0 : int'($urandom_range(1, 7)), int'($urandom_range(0, 15)));
            for (int c = 0; c < 150; c++)
                model_step($sformatf("rnd%0d_%0d", r, c), 1'($urandom), 1'($urandom), 1'b0, 1'b1);
            model_step($sformatf("rnd%0d_stop", r), 1'($urandom), 1'($urandom), 1'b1, 1'b1);
            guard = 0;
            while (mcnt > 0 && guard < 200) begin
                model_step($sformatf("rnd%0d_drain", r), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
                guard++;
            end
            if (guard >= 200) chk("drain_bound", 0, 1);
            finish_drain($sformatf("rnd%0d", r));
        end

`ifdef CFG_READBACK_EN
        corrupt = 1'b1;
        cfg_depth = 16'd4; cfg_almost = 4'd1;
        start = 1'b1;
        tick;
        start = 1'b0;
        flush_seen = 0; wr_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (flush) flush_seen++;
            if (config_write) wr_seen++;
            tick;
        end
        corrupt = 1'b0;
        chk("rb_cfg_err", cfg_err, 1);
        chk("rb_no_flush", flush_seen, 0);
        chk("rb_writes", wr_seen, 2);
        chk("rb_idle", busy, 0);
`else
        chk("no_rb_cfg_err", cfg_err, 0);
        chk("no_rb_cfg_rd", config_read, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
